light_display_driver: RTL and testbench
=======================================

# light_display_driver

Output stage of the traffic-light controller. Takes the light state and BCD countdown digits that the controller produces for directions A and B, latches them on a load strobe, and drives the physical outputs. Those outputs are two R/Y/G lamp groups and a four-digit multiplexed 7-segment countdown display. Flashing (wink) mode is generated locally.

## Interface
Parameters:
- SCAN_DIV, 50000: clocks per digit slot (≥2).
- BLINK_DIV, 25: full scan frames (4 slots) per blink half-period (≥1).

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Load  in  1  capture strobe for all light/time inputs.
- A_Light, B_Light  in  2 each  light code: 00 red, 01 green, 10 yellow, 11 wink.
- A_Time_H, A_Time_L, B_Time_H, B_Time_L  in  4 each  BCD countdown digits.
- Load_Ack  out  1  one-cycle pulse confirming capture.
- A_Lamp, B_Lamp  out  3 each  {R,Y,G}, active-high.
- Seg  out  7  {a..g}, active-low.
- Dig_En  out  4  digit enables, active-low; bit3 A_H, bit2 A_L, bit1 B_H, bit0 B_L.
- Bcd_Err  out  1  sticky flag: a captured digit was >9.

## Operation
- Reset values: shadow lights 00 (both red), shadow digits 0, A_Lamp=B_Lamp=3'b100, Seg=7'h7F, Dig_En=4'hF, Load_Ack=0, Bcd_Err=0, prescaler=0, slot=0, frame counter=0, blink phase=1 (lit).
- Capture: when Load=1, all six inputs are written to shadow registers on that edge. Load held high captures every cycle.
- Lamp decode from shadow:
  - 00 → 100.
  - 01 → 001.
  - 10 → 010.
  - 11 → {0, blink_phase, 0}.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap, slot advances 3→2→1→0→3 (A_H first). Slot sequence after reset is 3,2,1,0,...
  - On each slot-0→3 transition the frame counter increments.
  - At frame count BLINK_DIV-1 the frame counter clears and blink_phase toggles.
- Digit data: the selected shadow digit is encoded to 7-seg. Patterns, bit6=a:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100.
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- Blanking: Seg=1111111 when any of these holds:
  - the digit is >9;
  - the digit's direction is in wink mode (11);
  - the zero-suppression rule in Configuration applies.
- Anti-ghosting: Dig_En=4'hF during the cycle the prescaler is 0. Otherwise only the selected slot's bit is low.
- Bcd_Err: set on the edge where Load captures any digit >9. Cleared only by reset.

## Timing
- Load sampled high at edge n:
  - shadow, A_Lamp/B_Lamp and Load_Ack=1 all update at edge n.
  - Load_Ack falls at edge n+1 unless Load is still high.
- Seg and Dig_En are registered one cycle after slot/prescaler state. A new capture appears on the display at the next slot's first enabled cycle. The scan never restarts on Load.
- Wink lamp toggles exactly every 4·SCAN_DIV·BLINK_DIV clocks. Switching a direction into or out of wink does not reset blink_phase.
- Reset asserted mid-scan: all outputs take reset values immediately (asynchronous). Reset release starts slot 3 with prescaler 0.
- Load coincident with reset: reset wins, no capture, no Load_Ack.

## Configuration
- LIGHT_DISP_LZB_EN defined: a high digit (A_H, B_H) equal to 0 is blanked (leading-zero suppression). Low digits always show.
- Undefined: high digit 0 displays "0" (0000001).

## Test plan
- Reset check: assert Rst_n=0 mid-scan → A_Lamp=B_Lamp=100, Seg=7F, Dig_En=F, Load_Ack=0 at once. After release with SCAN_DIV=4, Dig_En low pattern follows 0111, 1011, 1101, 1110.
- Capture and display: Load pulse with A_Light=01, B_Light=00, A=2/5, B=3/0 → the next cycle shows A_Lamp=001, B_Lamp=100 and Load_Ack=1 for one cycle. The A_L slot shows Seg=0100100 and the B_L slot shows Seg=0000001.
- Wink: SCAN_DIV=4, BLINK_DIV=2, B_Light=11 → B_Lamp toggles between 010 and 000 every 32 clocks, and both B slots show Seg=7F.
- Invalid BCD: load A_Time_L=4'hC → the A_L slot is blank and Bcd_Err=1. After loading a valid digit Bcd_Err stays 1 until reset.
- Zero suppression: A_Time_H=0, A_Time_L=7 → the A_H slot shows 7F with LIGHT_DISP_LZB_EN defined, and 0000001 without it. The A_L slot shows 0001111 in both builds.
- Load held 3 cycles with changing inputs → Load_Ack high 3 cycles. The final values are retained, and the scan position is unaffected.

Source files
------------

// File: rtl/light_display_driver.sv
// Traffic-light output stage: latches light codes and BCD countdown digits, drives lamps and a 4-digit multiplexed 7-seg display.
// Optional build macro LIGHT_DISP_LZB_EN enables leading-zero blanking of the A_H/B_H digits.
module light_display_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Load,
  input  logic [1:0] A_Light,
  input  logic [1:0] B_Light,
  input  logic [3:0] A_Time_H,
  input  logic [3:0] A_Time_L,
  input  logic [3:0] B_Time_H,
  input  logic [3:0] B_Time_L,
  output logic       Load_Ack,
  output logic [2:0] A_Lamp,
  output logic [2:0] B_Lamp,
  output logic [6:0] Seg,
  output logic [3:0] Dig_En,
  output logic       Bcd_Err
);

  localparam int PSC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_DIV - 1);

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;
  localparam logic [1:0] LIGHT_WINK   = 2'b11;

  function automatic logic [6:0] seg7_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg7_enc = 7'b0000001;
      4'd1:    seg7_enc = 7'b1001111;
      4'd2:    seg7_enc = 7'b0010010;
      4'd3:    seg7_enc = 7'b0000110;
      4'd4:    seg7_enc = 7'b1001100;
      4'd5:    seg7_enc = 7'b0100100;
      4'd6:    seg7_enc = 7'b0100000;
      4'd7:    seg7_enc = 7'b0001111;
      4'd8:    seg7_enc = 7'b0000000;
      4'd9:    seg7_enc = 7'b0000100;
      default: seg7_enc = 7'b1111111;
    endcase
  endfunction

  function automatic logic [2:0] lamp_dec(input logic [1:0] code, input logic phase);
    case (code)
      LIGHT_RED:    lamp_dec = 3'b100;
      LIGHT_GREEN:  lamp_dec = 3'b001;
      LIGHT_YELLOW: lamp_dec = 3'b010;
      default:      lamp_dec = {1'b0, phase, 1'b0};
    endcase
  endfunction

  logic [1:0]       a_light_q, a_light_d, b_light_q, b_light_d;
  logic [3:0]       a_h_q, a_h_d, a_l_q, a_l_d, b_h_q, b_h_d, b_l_q, b_l_d;
  logic             load_ack_q, load_ack_d;
  logic             bcd_err_q, bcd_err_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [1:0]       slot_q, slot_d;
  logic [FRM_W-1:0] frame_q, frame_d;
  logic             blink_q, blink_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       dig_en_q, dig_en_d;

  logic             psc_wrap;
  logic [3:0]       sel_digit;
  logic             sel_wink;
  logic             zero_blank;

  always_comb begin
    a_light_d  = a_light_q;
    b_light_d  = b_light_q;
    a_h_d      = a_h_q;
    a_l_d      = a_l_q;
    b_h_d      = b_h_q;
    b_l_d      = b_l_q;
    if (Load) begin
      a_light_d = A_Light;
      b_light_d = B_Light;
      a_h_d     = A_Time_H;
      a_l_d     = A_Time_L;
      b_h_d     = B_Time_H;
      b_l_d     = B_Time_L;
    end
    load_ack_d = Load;
    bcd_err_d  = bcd_err_q | (Load & ((A_Time_H > 4'd9) | (A_Time_L > 4'd9) |
                                      (B_Time_H > 4'd9) | (B_Time_L > 4'd9)));

    // Scan timebase: slot walks 3,2,1,0 and each completed frame advances the blink divider.
    psc_wrap = (psc_q == PSC_LAST);
    psc_d    = psc_wrap ? '0 : psc_q + 1'b1;
    slot_d   = psc_wrap ? slot_q - 2'd1 : slot_q;
    frame_d  = frame_q;
    blink_d  = blink_q;
    if (psc_wrap && (slot_q == 2'd0)) begin
      if (frame_q == FRM_LAST) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    case (slot_q)
      2'd3:    sel_digit = a_h_q;
      2'd2:    sel_digit = a_l_q;
      2'd1:    sel_digit = b_h_q;
      default: sel_digit = b_l_q;
    endcase
    sel_wink = slot_q[1] ? (a_light_q == LIGHT_WINK) : (b_light_q == LIGHT_WINK);
`ifdef LIGHT_DISP_LZB_EN
    zero_blank = slot_q[0] && (sel_digit == 4'd0);
`else
    zero_blank = 1'b0;
`endif

    // Segment data is refreshed only in the dark cycle at slot start, so it never changes while a digit is lit.
    seg_d = seg_q;
    if (psc_q == '0) begin
      seg_d = (sel_wink || zero_blank) ? 7'h7F : seg7_enc(sel_digit);
    end
    dig_en_d = (psc_q == '0) ? 4'hF : ~(4'b0001 << slot_q);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_light_q  <= LIGHT_RED;
      b_light_q  <= LIGHT_RED;
      a_h_q      <= '0;
      a_l_q      <= '0;
      b_h_q      <= '0;
      b_l_q      <= '0;
      load_ack_q <= 1'b0;
      bcd_err_q  <= 1'b0;
      psc_q      <= '0;
      slot_q     <= 2'd3;
      frame_q    <= '0;
      blink_q    <= 1'b1;
      seg_q      <= 7'h7F;
      dig_en_q   <= 4'hF;
    end else begin
      a_light_q  <= a_light_d;
      b_light_q  <= b_light_d;
      a_h_q      <= a_h_d;
      a_l_q      <= a_l_d;
      b_h_q      <= b_h_d;
      b_l_q      <= b_l_d;
      load_ack_q <= load_ack_d;
      bcd_err_q  <= bcd_err_d;
      psc_q      <= psc_d;
      slot_q     <= slot_d;
      frame_q    <= frame_d;
      blink_q    <= blink_d;
      seg_q      <= seg_d;
      dig_en_q   <= dig_en_d;
    end
  end

  // Lamps decode straight from the shadow so a capture is visible on the same edge.
  assign A_Lamp   = lamp_dec(a_light_q, blink_q);
  assign B_Lamp   = lamp_dec(b_light_q, blink_q);
  assign Load_Ack = load_ack_q;
  assign Bcd_Err  = bcd_err_q;
  assign Seg      = seg_q;
  assign Dig_En   = dig_en_q;

endmodule

// File: tb/tb_light_display_driver.sv
// Directed bench for light_display_driver with SCAN_DIV=4, BLINK_DIV=2 (one frame = 16 clocks, wink half-period = 32).
module tb_light_display_driver;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b1;
  logic       Load = 1'b0;
  logic [1:0] A_Light = 2'b00, B_Light = 2'b00;
  logic [3:0] A_Time_H = 4'd0, A_Time_L = 4'd0, B_Time_H = 4'd0, B_Time_L = 4'd0;
  logic       Load_Ack;
  logic [2:0] A_Lamp, B_Lamp;
  logic [6:0] Seg;
  logic [3:0] Dig_En;
  logic       Bcd_Err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  light_display_driver #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Load(Load),
    .A_Light(A_Light), .B_Light(B_Light),
    .A_Time_H(A_Time_H), .A_Time_L(A_Time_L), .B_Time_H(B_Time_H), .B_Time_L(B_Time_L),
    .Load_Ack(Load_Ack), .A_Lamp(A_Lamp), .B_Lamp(B_Lamp),
    .Seg(Seg), .Dig_En(Dig_En), .Bcd_Err(Bcd_Err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk or negedge Rst_n)
    if (!Rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  // Expected Dig_En after k rising edges since reset release (4 clocks per slot, slot 3 first).
  function automatic logic [3:0] exp_dig(input int k);
    int p, s;
    if (k == 0) return 4'hF;
    p = (k - 1) % 4;
    s = 3 - ((k - 1) / 4) % 4;
    if (p == 0) return 4'hF;
    return ~(4'b0001 << s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for a dark cycle, then for the requested digit enable, and check the segments shown there.
  task automatic slot_seg(input string tag, input logic [3:0] pat, input logic [6:0] exp_seg);
    bit seen_dark = 0;
    bit found = 0;
    int n = 0;
    while (!found && n < 64) begin
      @(negedge Clk);
      n++;
      if (Dig_En === 4'hF) seen_dark = 1;
      else if (seen_dark && Dig_En === pat) found = 1;
    end
    if (found) chk(tag, {25'd0, Seg}, {25'd0, exp_seg});
    else       chk({tag, "_timeout"}, {28'd0, Dig_En}, {28'd0, pat});
  endtask

  task automatic load_vec(input logic [1:0] al, bl, input logic [3:0] ah, alo, bh, blo);
    A_Light = al; B_Light = bl;
    A_Time_H = ah; A_Time_L = alo; B_Time_H = bh; B_Time_L = blo;
    Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
  endtask

  initial begin
    logic [3:0] dig_tab [16];
    logic [2:0] prev;
    int n;
    dig_tab = '{4'hF, 4'h7, 4'h7, 4'h7, 4'hF, 4'hB, 4'hB, 4'hB,
                4'hF, 4'hD, 4'hD, 4'hD, 4'hF, 4'hE, 4'hE, 4'hE};

    // Reset, with Load high to show reset wins
    #2 Rst_n = 1'b0;
    Load = 1'b1; A_Light = 2'b01; A_Time_L = 4'hC;
    #1;
    chk("rst_a_lamp", {29'd0, A_Lamp}, 32'h4);
    chk("rst_b_lamp", {29'd0, B_Lamp}, 32'h4);
    chk("rst_seg", {25'd0, Seg}, 32'h7F);
    chk("rst_dig_en", {28'd0, Dig_En}, 32'hF);
    chk("rst_load_ack", {31'd0, Load_Ack}, 32'h0);
    @(negedge Clk);
    chk("rst_no_capture", {29'd0, A_Lamp}, 32'h4);
    chk("rst_bcd_err", {31'd0, Bcd_Err}, 32'h0);
    Load = 1'b0; A_Light = 2'b00; A_Time_L = 4'd0;
    @(negedge Clk);
    Rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      chk($sformatf("scan_seq_%0d", i), {28'd0, Dig_En}, {28'd0, dig_tab[i]});
    end

    // Capture and display
    load_vec(2'b01, 2'b00, 4'd2, 4'd5, 4'd3, 4'd0);
    chk("cap_a_lamp", {29'd0, A_Lamp}, 32'h1);
    chk("cap_b_lamp", {29'd0, B_Lamp}, 32'h4);
    chk("cap_ack_hi", {31'd0, Load_Ack}, 32'h1);
    @(negedge Clk);
    chk("cap_ack_lo", {31'd0, Load_Ack}, 32'h0);
    slot_seg("cap_a_h", 4'b0111, 7'b0010010);
    slot_seg("cap_a_l", 4'b1011, 7'b0100100);
    slot_seg("cap_b_h", 4'b1101, 7'b0000110);
    slot_seg("cap_b_l", 4'b1110, 7'b0000001);

    // Wink on B
    load_vec(2'b01, 2'b11, 4'd2, 4'd5, 4'd3, 4'd0);
    chk("wink_shape", {29'd0, B_Lamp & 3'b101}, 32'h0);
    chk("wink_a_lamp", {29'd0, A_Lamp}, 32'h1);
    prev = B_Lamp; n = 0;
    while (B_Lamp === prev && n < 80) begin @(negedge Clk); n++; end
    chk("wink_first_edge", {31'd0, (B_Lamp !== prev)}, 32'h1);
    prev = B_Lamp; n = 0;
    while (B_Lamp === prev && n < 80) begin @(negedge Clk); n++; end
    chk("wink_period", n, 32);
    chk("wink_toggle", {29'd0, B_Lamp}, {29'd0, prev ^ 3'b010});
    slot_seg("wink_b_h", 4'b1101, 7'h7F);
    slot_seg("wink_b_l", 4'b1110, 7'h7F);
    slot_seg("wink_a_l", 4'b1011, 7'b0100100);

    // Invalid BCD digit
    load_vec(2'b00, 2'b00, 4'd1, 4'hC, 4'd4, 4'd9);
    chk("bcd_err_set", {31'd0, Bcd_Err}, 32'h1);
    slot_seg("bcd_a_l_blank", 4'b1011, 7'h7F);
    slot_seg("bcd_b_l", 4'b1110, 7'b0000100);
    load_vec(2'b00, 2'b00, 4'd0, 4'd7, 4'd8, 4'd6);
    @(negedge Clk);
    chk("bcd_err_sticky", {31'd0, Bcd_Err}, 32'h1);

    // Leading zero on A_H
`ifdef LIGHT_DISP_LZB_EN
    slot_seg("lz_a_h", 4'b0111, 7'h7F);
`else
    slot_seg("lz_a_h", 4'b0111, 7'b0000001);
`endif
    slot_seg("lz_a_l", 4'b1011, 7'b0001111);
    slot_seg("lz_b_h", 4'b1101, 7'b0000000);

    // Load held for three cycles with changing data
    A_Light = 2'b01; B_Light = 2'b10;
    A_Time_H = 4'd1; A_Time_L = 4'd1; B_Time_H = 4'd1; B_Time_L = 4'd1;
    Load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk($sformatf("hold_ack_%0d", i), {31'd0, Load_Ack}, 32'h1);
      chk($sformatf("hold_scan_%0d", i), {28'd0, Dig_En}, {28'd0, exp_dig(cyc)});
      A_Light = 2'b10; B_Light = 2'b01;
      A_Time_H = 4'(i + 2); A_Time_L = 4'd3; B_Time_H = 4'd4; B_Time_L = 4'd8;
      if (i == 2) Load = 1'b0;
    end
    @(negedge Clk);
    chk("hold_ack_lo", {31'd0, Load_Ack}, 32'h0);
    chk("hold_a_lamp", {29'd0, A_Lamp}, 32'h2);
    chk("hold_b_lamp", {29'd0, B_Lamp}, 32'h1);
    slot_seg("hold_a_h", 4'b0111, 7'b0000110);
    chk("hold_scan_after", {28'd0, Dig_En}, {28'd0, exp_dig(cyc)});
    slot_seg("hold_b_l", 4'b1110, 7'b0000000);

    // Reset asserted mid-scan
    @(negedge Clk);
    #1 Rst_n = 1'b0;
    #1;
    chk("mid_rst_a_lamp", {29'd0, A_Lamp}, 32'h4);
    chk("mid_rst_b_lamp", {29'd0, B_Lamp}, 32'h4);
    chk("mid_rst_seg", {25'd0, Seg}, 32'h7F);
    chk("mid_rst_dig_en", {28'd0, Dig_En}, 32'hF);
    chk("mid_rst_bcd_err", {31'd0, Bcd_Err}, 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      chk($sformatf("rerun_scan_%0d", i), {28'd0, Dig_En}, {28'd0, dig_tab[i]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
